// File: rtl/rc4_pkg.sv
// Shared types and sizing for the rc4 stream controller and its output stage.
package rc4_pkg;

  localparam int KEY_W         = 32;
  localparam int MAX_KEY_BYTES = 4;
  localparam int BYTE_W        = 8;

  typedef enum logic [2:0] {IDLE, START, KSA, DROP, STREAM, FLUSH} state_t;

  // Core contract: ksa_done is a level that holds until the next start; while
  // ks_valid is high, ks_byte is stable until ks_ready is seen at a clock edge.
  typedef struct packed {
    logic              ksa_done;
    logic              ks_valid;
    logic [BYTE_W-1:0] ks_byte;
  } core_rsp_t;

  function automatic logic key_len_ok(input logic [7:0] len);
    return (len != 8'd0) && (len <= 8'(MAX_KEY_BYTES));
  endfunction

endpackage

// File: rtl/rc4_xor_stage.sv
// Single-entry output register holding din ^ keystream; one cycle load-to-valid.
// Refills in the same cycle the old byte drains, so it sustains 1 byte/cycle.
module rc4_xor_stage
  import rc4_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic              last_in,
  input  logic [BYTE_W-1:0] din_data,
  input  logic [BYTE_W-1:0] ks_byte,
  input  logic              dout_ready,
  output logic              dout_valid,
  output logic              dout_last,
  output logic [BYTE_W-1:0] dout_data,
  output logic              room
);

  assign room = ~dout_valid | dout_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      dout_data  <= '0;
    end else if (clr) begin
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
    end else if (load) begin
      dout_data  <= din_data ^ ks_byte;
      dout_valid <= 1'b1;
      dout_last  <= last_in;
    end else if (dout_valid && dout_ready) begin
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/rc4_stream_ctrl.sv
// Command sequencer around an rc4 core: key load, KSA wait, optional drop, then
// XOR streaming; one cycle din-to-dout, stalls din when core or downstream stalls.
module rc4_stream_ctrl
  import rc4_pkg::*;
#(
  parameter int DROP_N = 0,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [KEY_W-1:0]  cmd_key,
  input  logic [7:0]        cmd_key_len,
  input  logic [LEN_W-1:0]  cmd_msg_len,
  input  logic              abort,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic [BYTE_W-1:0] din_data,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [BYTE_W-1:0] dout_data,
  output logic              dout_last,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [KEY_W-1:0]  core_key,
  output logic [7:0]        core_key_len,
  output logic              core_start,
  input  logic              core_ksa_done,
  input  logic              core_ks_valid,
  input  logic [BYTE_W-1:0] core_ks_byte,
  output logic              core_ks_ready
);

  localparam int DROP_W = 10;

  state_t           state;
  state_t           after_drop;
  core_rsp_t        rsp;
  logic [LEN_W-1:0] msg_len;
  logic [LEN_W-1:0] byte_cnt;
  logic [DROP_W-1:0] drop_cnt;
  logic             kill;
  logic             room;
  logic             fire;
  logic             last_byte;

  assign rsp        = '{ksa_done: core_ksa_done, ks_valid: core_ks_valid, ks_byte: core_ks_byte};
  assign kill       = abort && (state != IDLE);
  assign cmd_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign core_start = (state == START);
  assign after_drop = (msg_len == '0) ? FLUSH : STREAM;
  assign last_byte  = (byte_cnt == msg_len - 1'b1);

  // An aborting cycle must not consume keystream or input, or bytes would be lost.
  assign din_ready     = (state == STREAM) && !kill && rsp.ks_valid && room;
  assign fire          = din_ready && din_valid;
  assign core_ks_ready = fire || ((state == DROP) && !kill && rsp.ks_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      core_key     <= '0;
      core_key_len <= '0;
      msg_len      <= '0;
      byte_cnt     <= '0;
      drop_cnt     <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (kill) begin
        state    <= IDLE;
        byte_cnt <= '0;
        drop_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (cmd_valid) begin
              if (key_len_ok(cmd_key_len)) begin
                core_key     <= cmd_key;
                core_key_len <= cmd_key_len;
                msg_len      <= cmd_msg_len;
                byte_cnt     <= '0;
                drop_cnt     <= '0;
                state        <= START;
              end else begin
                err <= 1'b1;
              end
            end
          end
          START: state <= KSA;
          KSA: begin
            if (rsp.ksa_done) state <= (DROP_N > 0) ? DROP : after_drop;
          end
          DROP: begin
            if (rsp.ks_valid) begin
              if (drop_cnt == DROP_W'(DROP_N - 1)) state <= after_drop;
              else drop_cnt <= drop_cnt + 1'b1;
            end
          end
          STREAM: begin
            if (fire) begin
              byte_cnt <= byte_cnt + 1'b1;
              if (last_byte) state <= FLUSH;
            end
          end
          FLUSH: begin
            if (room) begin
              done  <= 1'b1;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  rc4_xor_stage u_xor (
    .clk        (clk),
    .rst        (rst),
    .clr        (kill),
    .load       (fire),
    .last_in    (last_byte),
    .din_data   (din_data),
    .ks_byte    (rsp.ks_byte),
    .dout_ready (dout_ready),
    .dout_valid (dout_valid),
    .dout_last  (dout_last),
    .dout_data  (dout_data),
    .room       (room)
  );

endmodule
